// File: rtl/csi_pkg.sv
// Shared CSI-2 receive definitions: data types, packet FSM states, header ECC and CRC byte step.
// Pure declarations and combinational helper functions; no timing of its own.
// No flow control here; the state set grows by one when CSI_RX_CRC_CHECK_EN is defined.
package csi_pkg;

  localparam logic [5:0] DT_FSC   = 6'h00;
  localparam logic [5:0] DT_FEC   = 6'h01;
  localparam logic [5:0] DT_LSC   = 6'h02;
  localparam logic [5:0] DT_LEC   = 6'h03;
  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;

  // First data type that denotes a long packet.
  localparam logic [5:0] DT_LONG_MIN = 6'h10;

  localparam logic [15:0] CRC_SEED = 16'hFFFF;

`ifdef CSI_RX_CRC_CHECK_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_CRC     = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;
`endif

  // 6-bit Hamming parity over d = {WC, DI}; d[0] is DI bit 0.
  function automatic logic [5:0] csi_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  // CRC-16 x^16+x^12+x^5+1 in reflected form, one byte, data bits LSB first.
  function automatic logic [15:0] csi_crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/csi_crc16_x4.sv
// Running CRC-16 over up to four bytes per cycle, earliest byte at [31:24], masked by be_i.
// crc_nxt_o is combinational from the current state; crc_o is the registered running value.
// No backpressure: accumulates every cycle vld_i is high; init_i reloads the seed.
module csi_crc16_x4
  import csi_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        init_i,
  input  logic        vld_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  be_i,
  output logic [15:0] crc_nxt_o,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;
  logic [15:0] acc;

  // Fold the enabled bytes into the running CRC in stream order.
  always_comb begin
    acc = crc_q;
    if (be_i[3]) acc = csi_crc16_byte(acc, data_i[31:24]);
    if (be_i[2]) acc = csi_crc16_byte(acc, data_i[23:16]);
    if (be_i[1]) acc = csi_crc16_byte(acc, data_i[15:8]);
    if (be_i[0]) acc = csi_crc16_byte(acc, data_i[7:0]);
    crc_d = init_i ? CRC_SEED : (vld_i ? acc : crc_q);
  end

  // Running CRC register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) crc_q <= CRC_SEED;
    else         crc_q <= crc_d;
  end

  assign crc_nxt_o = acc;
  assign crc_o     = crc_q;

endmodule

// File: rtl/csi_rx_packet_ctrl.sv
// CSI-2 packet sequencer: header ECC check, frame state per VC, word-count payload forwarding.
// All outputs registered, 1 cycle after the PPI word; CRC check included when CSI_RX_CRC_CHECK_EN.
// No backpressure: downstream must take one word per cycle; PHY valid loss truncates the packet.
module csi_rx_packet_ctrl
  import csi_pkg::*;
#(
  parameter int MIPI_LANES = 4,
  parameter int MIPI_GEAR  = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [MIPI_LANES-1:0]           rx_valid_i,
  input  logic [MIPI_LANES*MIPI_GEAR-1:0] rx_data_i,
  output logic [31:0]                     pix_data_o,
  output logic [3:0]                      pix_be_o,
  output logic                            pix_valid_o,
  output logic                            pix_last_o,
  output logic [5:0]                      pix_dt_o,
  output logic [1:0]                      pix_vc_o,
  output logic [3:0]                      frame_valid_o,
  output logic                            line_valid_o,
  output logic [15:0]                     frame_num_o,
  output logic                            err_ecc_o,
  output logic                            err_crc_o,
  output logic                            err_trunc_o,
  output logic                            err_sync_o
);

  state_e      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [5:0]  dt_q, dt_d;
  logic [1:0]  vc_q, vc_d;
  logic [31:0] pix_data_q, pix_data_d;
  logic [3:0]  pix_be_q, pix_be_d;
  logic        pix_valid_q, pix_valid_d;
  logic        pix_last_q, pix_last_d;
  logic        line_valid_q, line_valid_d;
  logic [3:0]  frame_valid_q, frame_valid_d;
  logic [15:0] frame_num_q, frame_num_d;
  logic        err_ecc_q, err_ecc_d;
  logic        err_trunc_q, err_trunc_d;
  logic        err_sync_q, err_sync_d;

  logic        rx_valid;
  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;
  logic [15:0] hdr_wc;
  logic [5:0]  hdr_syn;
  logic [3:0]  be_fin;

  assign rx_valid = &rx_valid_i;
  assign hdr_vc   = rx_data_i[31:30];
  assign hdr_dt   = rx_data_i[29:24];
  assign hdr_wc   = {rx_data_i[15:8], rx_data_i[23:16]};
  assign hdr_syn  = csi_ecc({hdr_wc, rx_data_i[31:24]}) ^ rx_data_i[5:0];

`ifdef CSI_RX_CRC_CHECK_EN
  logic        crc_init, crc_vld;
  logic [15:0] crc_nxt, crc_cur;
  logic [7:0]  crc_lo_q, crc_lo_d;
  logic        crc_hi_only_q, crc_hi_only_d;
  logic        err_crc_q, err_crc_d;

  csi_crc16_x4 u_crc (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .init_i    (crc_init),
    .vld_i     (crc_vld),
    .data_i    (rx_data_i),
    .be_i      (pix_be_d),
    .crc_nxt_o (crc_nxt),
    .crc_o     (crc_cur)
  );
`endif

  // Byte enables of the final payload word: top 'remaining' lanes.
  always_comb begin
    case (rem_q[2:0])
      3'd1:    be_fin = 4'b1000;
      3'd2:    be_fin = 4'b1100;
      3'd3:    be_fin = 4'b1110;
      default: be_fin = 4'b1111;
    endcase
  end

  // Packet FSM next state and next values of every registered output.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    dt_d          = dt_q;
    vc_d          = vc_q;
    pix_data_d    = '0;
    pix_be_d      = '0;
    pix_valid_d   = 1'b0;
    pix_last_d    = 1'b0;
    line_valid_d  = 1'b0;
    frame_valid_d = frame_valid_q;
    frame_num_d   = frame_num_q;
    err_ecc_d     = 1'b0;
    err_trunc_d   = 1'b0;
    err_sync_d    = 1'b0;
`ifdef CSI_RX_CRC_CHECK_EN
    crc_init      = 1'b0;
    crc_vld       = 1'b0;
    crc_lo_d      = crc_lo_q;
    crc_hi_only_d = crc_hi_only_q;
    err_crc_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          state_d = ST_DRAIN;
          if (hdr_syn != 6'd0) begin
            err_ecc_d = 1'b1;
          end else if (hdr_dt < DT_LONG_MIN) begin
            // A rejected FS/FE leaves frame state untouched.
            if (hdr_dt == DT_FSC) begin
              if (frame_valid_q[hdr_vc]) err_sync_d = 1'b1;
              else begin
                frame_valid_d[hdr_vc] = 1'b1;
                frame_num_d           = hdr_wc;
              end
            end else if (hdr_dt == DT_FEC) begin
              if (!frame_valid_q[hdr_vc]) err_sync_d = 1'b1;
              else frame_valid_d[hdr_vc] = 1'b0;
            end
          end else if (!frame_valid_q[hdr_vc]) begin
            // Lines outside a frame are flagged and dropped.
            err_sync_d = 1'b1;
          end else begin
            dt_d  = hdr_dt;
            vc_d  = hdr_vc;
            rem_d = hdr_wc;
`ifdef CSI_RX_CRC_CHECK_EN
            crc_init      = 1'b1;
            crc_hi_only_d = 1'b0;
            state_d       = (hdr_wc == 16'd0) ? ST_CRC : ST_PAYLOAD;
`else
            state_d       = (hdr_wc == 16'd0) ? ST_DRAIN : ST_PAYLOAD;
`endif
          end
        end
      end
      ST_PAYLOAD: begin
        if (!rx_valid) begin
          err_trunc_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          pix_valid_d  = 1'b1;
          line_valid_d = 1'b1;
          pix_data_d   = rx_data_i;
          if (rem_q > 16'd4) begin
            pix_be_d = 4'b1111;
            rem_d    = rem_q - 16'd4;
          end else begin
            pix_be_d   = be_fin;
            pix_last_d = 1'b1;
            rem_d      = '0;
            state_d    = ST_DRAIN;
`ifdef CSI_RX_CRC_CHECK_EN
            // CRC bytes follow the last payload byte, LSB first; they may spill into the next word.
            case (rem_q[2:0])
              3'd1: err_crc_d = crc_nxt != {rx_data_i[15:8], rx_data_i[23:16]};
              3'd2: err_crc_d = crc_nxt != {rx_data_i[7:0], rx_data_i[15:8]};
              3'd3: begin
                crc_lo_d      = rx_data_i[7:0];
                crc_hi_only_d = 1'b1;
                state_d       = ST_CRC;
              end
              default: begin
                crc_hi_only_d = 1'b0;
                state_d       = ST_CRC;
              end
            endcase
`endif
          end
`ifdef CSI_RX_CRC_CHECK_EN
          crc_vld = 1'b1;
`endif
        end
      end
`ifdef CSI_RX_CRC_CHECK_EN
      ST_CRC: begin
        if (!rx_valid) begin
          err_trunc_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          if (crc_hi_only_q) err_crc_d = crc_cur != {rx_data_i[31:24], crc_lo_q};
          else               err_crc_d = crc_cur != {rx_data_i[23:16], rx_data_i[31:24]};
          state_d = ST_DRAIN;
        end
      end
`endif
      ST_DRAIN: begin
        if (!rx_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      rem_q         <= '0;
      dt_q          <= '0;
      vc_q          <= '0;
      pix_data_q    <= '0;
      pix_be_q      <= '0;
      pix_valid_q   <= 1'b0;
      pix_last_q    <= 1'b0;
      line_valid_q  <= 1'b0;
      frame_valid_q <= '0;
      frame_num_q   <= '0;
      err_ecc_q     <= 1'b0;
      err_trunc_q   <= 1'b0;
      err_sync_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      dt_q          <= dt_d;
      vc_q          <= vc_d;
      pix_data_q    <= pix_data_d;
      pix_be_q      <= pix_be_d;
      pix_valid_q   <= pix_valid_d;
      pix_last_q    <= pix_last_d;
      line_valid_q  <= line_valid_d;
      frame_valid_q <= frame_valid_d;
      frame_num_q   <= frame_num_d;
      err_ecc_q     <= err_ecc_d;
      err_trunc_q   <= err_trunc_d;
      err_sync_q    <= err_sync_d;
    end
  end

`ifdef CSI_RX_CRC_CHECK_EN
  // CRC capture state and error pulse.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      crc_lo_q      <= '0;
      crc_hi_only_q <= 1'b0;
      err_crc_q     <= 1'b0;
    end else begin
      crc_lo_q      <= crc_lo_d;
      crc_hi_only_q <= crc_hi_only_d;
      err_crc_q     <= err_crc_d;
    end
  end
  assign err_crc_o = err_crc_q;
`else
  assign err_crc_o = 1'b0;
`endif

  assign pix_data_o    = pix_data_q;
  assign pix_be_o      = pix_be_q;
  assign pix_valid_o   = pix_valid_q;
  assign pix_last_o    = pix_last_q;
  assign pix_dt_o      = dt_q;
  assign pix_vc_o      = vc_q;
  assign frame_valid_o = frame_valid_q;
  assign line_valid_o  = line_valid_q;
  assign frame_num_o   = frame_num_q;
  assign err_ecc_o     = err_ecc_q;
  assign err_trunc_o   = err_trunc_q;
  assign err_sync_o    = err_sync_q;

endmodule

// File: tb/tb_csi_rx_packet_ctrl.sv
// Directed bench for csi_rx_packet_ctrl: header vector table plus long-packet sequences.
// Outputs are sampled 1 time unit after each rising clock edge.
// The stream never stalls; each packet ends with idle cycles so the block returns to IDLE.
module tb_csi_rx_packet_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [3:0]  rx_valid_i;
  logic [31:0] rx_data_i;
  logic [31:0] pix_data_o;
  logic [3:0]  pix_be_o;
  logic        pix_valid_o, pix_last_o;
  logic [5:0]  pix_dt_o;
  logic [1:0]  pix_vc_o;
  logic [3:0]  frame_valid_o;
  logic        line_valid_o;
  logic [15:0] frame_num_o;
  logic        err_ecc_o, err_crc_o, err_trunc_o, err_sync_o;

  csi_rx_packet_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .pix_data_o(pix_data_o), .pix_be_o(pix_be_o), .pix_valid_o(pix_valid_o),
    .pix_last_o(pix_last_o), .pix_dt_o(pix_dt_o), .pix_vc_o(pix_vc_o),
    .frame_valid_o(frame_valid_o), .line_valid_o(line_valid_o), .frame_num_o(frame_num_o),
    .err_ecc_o(err_ecc_o), .err_crc_o(err_crc_o), .err_trunc_o(err_trunc_o),
    .err_sync_o(err_sync_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef CSI_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  // Syndrome column of each header bit d[i], d = {WC, DI}.
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] ecc_of(input logic [7:0] di, input logic [15:0] wc);
    logic [23:0] d;
    logic [5:0]  e;
    d = {wc, di};
    e = '0;
    for (int i = 0; i < 24; i++) if (d[i]) e = e ^ ECC_COL[i];
    return e;
  endfunction

  // Non-reflected shift register fed LSB-first; transmitted CRC is its bit reversal.
  function automatic logic [15:0] crc_of(input logic [7:0] b[$]);
    logic [15:0] r, o;
    logic        fb;
    r = 16'hFFFF;
    foreach (b[k]) begin
      for (int j = 0; j < 8; j++) begin
        fb = r[15] ^ b[k][j];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h1021;
      end
    end
    for (int i = 0; i < 16; i++) o[i] = r[15 - i];
    return o;
  endfunction

  function automatic logic [31:0] hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    logic [7:0] di;
    di = {vc, dt};
    return {di, wc[7:0], wc[15:8], 2'b00, ecc_of(di, wc)};
  endfunction

  task automatic drive(input logic [3:0] v, input logic [31:0] d);
    rx_valid_i = v;
    rx_data_i  = d;
    @(posedge clk_i);
    #1;
  endtask

  // Expected payload words for the packet in flight, and what was seen of it.
  logic [31:0] ex_data[$];
  logic [3:0]  ex_be[$];
  logic        ex_last[$];
  logic [5:0]  ex_dt;
  logic [1:0]  ex_vc;
  int          got_words, got_last;
  bit          saw_trunc, saw_crc, saw_ecc, saw_sync;

  task automatic observe();
    logic [31:0] d, m;
    logic [3:0]  b;
    logic        l;
    if (pix_valid_o) begin
      if (ex_data.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_word: got data 0x%0h be 0x%0h, expected no word", pix_data_o, pix_be_o);
      end else begin
        d = ex_data.pop_front();
        b = ex_be.pop_front();
        l = ex_last.pop_front();
        m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        check($sformatf("pix_data w%0d", got_words), pix_data_o & m, d & m);
        check($sformatf("pix_be w%0d", got_words), 32'(pix_be_o), 32'(b));
        check($sformatf("pix_last w%0d", got_words), 32'(pix_last_o), 32'(l));
        check($sformatf("line_vc_dt w%0d", got_words), {23'd0, line_valid_o, pix_vc_o, pix_dt_o},
              {23'd0, 1'b1, ex_vc, ex_dt});
        got_words++;
      end
    end
    if (pix_last_o)  got_last++;
    if (err_trunc_o) saw_trunc = 1'b1;
    if (err_crc_o)   saw_crc   = 1'b1;
    if (err_ecc_o)   saw_ecc   = 1'b1;
    if (err_sync_o)  saw_sync  = 1'b1;
  endtask

  // Long packet: header, payload, CRC, 0xFF pad and fill words, then two idle cycles.
  task automatic send_long(input string tag, input logic [1:0] vc, input logic [5:0] dt,
                           input logic [15:0] wc, input int fill, input int trunc_after,
                           input bit bad_crc, input logic [31:0] flip, input bit exp_sync);
    logic [7:0]  pl[$];
    logic [7:0]  st[$];
    logic [15:0] crc;
    logic [31:0] d;
    logic [3:0]  b;
    int          n_exp, n_in, idx;
    bit          dropped, trunc;
    ex_data.delete(); ex_be.delete(); ex_last.delete();
    got_words = 0; got_last = 0;
    saw_trunc = 0; saw_crc = 0; saw_ecc = 0; saw_sync = 0;
    ex_dt = dt;
    ex_vc = vc;
    for (int i = 0; i < int'(wc); i++) pl.push_back(8'((i * 37 + 17 + int'(wc)) & 255));
    crc = crc_of(pl);
    st = pl;
    st.push_back(crc[7:0] ^ (bad_crc ? 8'h01 : 8'h00));
    st.push_back(crc[15:8]);
    while (st.size() % 4 != 0) st.push_back(8'hFF);
    for (int i = 0; i < fill * 4; i++) st.push_back(8'hFF);
    dropped = (flip != 32'd0) || exp_sync;
    trunc   = trunc_after >= 0;
    n_exp   = dropped ? 0 : (trunc ? trunc_after : (int'(wc) + 3) / 4);
    for (int k = 0; k < n_exp; k++) begin
      for (int j = 0; j < 4; j++) begin
        idx = 4 * k + j;
        b[3 - j] = idx < int'(wc);
        d[31 - 8 * j -: 8] = (idx < int'(wc)) ? pl[idx] : 8'h00;
      end
      ex_data.push_back(d);
      ex_be.push_back(b);
      ex_last.push_back(!trunc && (k == n_exp - 1));
    end
    drive(4'hF, hdr(vc, dt, wc) ^ flip);
    observe();
    n_in = trunc ? trunc_after : st.size() / 4;
    for (int k = 0; k < n_in; k++) begin
      drive(4'hF, {st[4 * k], st[4 * k + 1], st[4 * k + 2], st[4 * k + 3]});
      observe();
    end
    // Partial lane-valid must still count as the stream being idle.
    drive(trunc ? 4'b0111 : 4'h0, 32'hFFFF_FFFF);
    observe();
    drive(4'h0, 32'h0);
    observe();
    check({tag, " words"}, got_words, n_exp);
    check({tag, " last"}, got_last, (dropped || trunc || wc == 16'd0) ? 0 : 1);
    check({tag, " err_trunc"}, 32'(saw_trunc), 32'(trunc && !dropped));
    check({tag, " err_crc"}, 32'(saw_crc), 32'(CRC_EN && bad_crc && !dropped && !trunc));
    check({tag, " err_ecc"}, 32'(saw_ecc), 32'(flip != 32'd0));
    check({tag, " err_sync"}, 32'(saw_sync), 32'(exp_sync));
  endtask

  typedef struct {
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [31:0] flip;
    logic [3:0]  fv;
    logic [15:0] fnum;
    logic        ecc;
    logic        sync;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{2'd0, 6'h00, 16'h0007, 32'h0,  4'b0001, 16'h0007, 1'b0, 1'b0}; // FS vc0
    tbl[1]  = '{2'd0, 6'h00, 16'h0009, 32'h0,  4'b0001, 16'h0007, 1'b0, 1'b1}; // FS on open frame
    tbl[2]  = '{2'd1, 6'h01, 16'h0000, 32'h0,  4'b0001, 16'h0007, 1'b0, 1'b1}; // FE vc1, none open
    tbl[3]  = '{2'd2, 6'h00, 16'h1234, 32'h0,  4'b0101, 16'h1234, 1'b0, 1'b0}; // FS vc2
    tbl[4]  = '{2'd1, 6'h00, 16'h0055, 32'h20, 4'b0101, 16'h1234, 1'b1, 1'b0}; // ECC bit 5 flipped
    tbl[5]  = '{2'd2, 6'h01, 16'h0000, 32'h0,  4'b0001, 16'h1234, 1'b0, 1'b0}; // FE vc2
    tbl[6]  = '{2'd0, 6'h08, 16'hABCD, 32'h0,  4'b0001, 16'h1234, 1'b0, 1'b0}; // generic short
    tbl[7]  = '{2'd0, 6'h01, 16'h0000, 32'h0,  4'b0000, 16'h1234, 1'b0, 1'b0}; // FE vc0
    tbl[8]  = '{2'd3, 6'h00, 16'h00FF, 32'hC0, 4'b1000, 16'h00FF, 1'b0, 1'b0}; // ECC bits 7:6 ignored
    tbl[9]  = '{2'd3, 6'h01, 16'h0000, 32'h0,  4'b0000, 16'h00FF, 1'b0, 1'b0}; // FE vc3
    tbl[10] = '{2'd0, 6'h00, 16'h0000, 32'h0,  4'b0001, 16'h0000, 1'b0, 1'b0}; // FS vc0, WC 0

    reset_i    = 1'b1;
    rx_valid_i = 4'h0;
    rx_data_i  = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst pix_valid", 32'(pix_valid_o), 0);
    check("rst pix_last", 32'(pix_last_o), 0);
    check("rst pix_data", pix_data_o, 0);
    check("rst pix_be", 32'(pix_be_o), 0);
    check("rst dt_vc", {24'd0, pix_vc_o, pix_dt_o}, 0);
    check("rst frame_valid", 32'(frame_valid_o), 0);
    check("rst line_valid", 32'(line_valid_o), 0);
    check("rst frame_num", 32'(frame_num_o), 0);
    check("rst errors", {28'd0, err_ecc_o, err_crc_o, err_trunc_o, err_sync_o}, 0);
    reset_i = 1'b0;
    drive(4'h0, 32'h0);

    // Short-packet header table: one header cycle, then one idle cycle.
    for (int i = 0; i < 11; i++) begin
      drive(4'hF, hdr(tbl[i].vc, tbl[i].dt, tbl[i].wc) ^ tbl[i].flip);
      check($sformatf("v%0d frame_valid", i), 32'(frame_valid_o), 32'(tbl[i].fv));
      check($sformatf("v%0d frame_num", i), 32'(frame_num_o), 32'(tbl[i].fnum));
      check($sformatf("v%0d err_ecc", i), 32'(err_ecc_o), 32'(tbl[i].ecc));
      check($sformatf("v%0d err_sync", i), 32'(err_sync_o), 32'(tbl[i].sync));
      check($sformatf("v%0d pix_valid", i), 32'(pix_valid_o), 0);
      drive(4'h0, 32'h0);
      check($sformatf("v%0d pulse_end", i), {30'd0, err_ecc_o, err_sync_o}, 0);
    end

    send_long("raw8_512", 2'd0, 6'h2A, 16'd512, 20, -1, 1'b0, 32'h0, 1'b0);
    check("raw8 frame_valid", 32'(frame_valid_o), 32'h1);
    send_long("raw10_640", 2'd0, 6'h2B, 16'd640, 0, -1, 1'b0, 32'h0, 1'b0);
    send_long("wc6", 2'd0, 6'h2A, 16'd6, 1, -1, 1'b0, 32'h0, 1'b0);
    send_long("wc5", 2'd0, 6'h12, 16'd5, 0, -1, 1'b0, 32'h0, 1'b0);
    send_long("wc7", 2'd0, 6'h2A, 16'd7, 0, -1, 1'b0, 32'h0, 1'b0);
    send_long("wc8", 2'd0, 6'h2A, 16'd8, 2, -1, 1'b0, 32'h0, 1'b0);
    send_long("wc0", 2'd0, 6'h2A, 16'd0, 0, -1, 1'b0, 32'h0, 1'b0);
    send_long("ecc_bad", 2'd0, 6'h2A, 16'd512, 0, -1, 1'b0, 32'h20, 1'b0);
    send_long("after_ecc", 2'd0, 6'h2A, 16'd16, 0, -1, 1'b0, 32'h0, 1'b0);
    send_long("trunc", 2'd0, 6'h2A, 16'd512, 0, 10, 1'b0, 32'h0, 1'b0);
    send_long("crc_bad6", 2'd0, 6'h2A, 16'd6, 0, -1, 1'b1, 32'h0, 1'b0);
    send_long("crc_bad7", 2'd0, 6'h2A, 16'd7, 0, -1, 1'b1, 32'h0, 1'b0);
    send_long("crc_bad8", 2'd0, 6'h2B, 16'd8, 0, -1, 1'b1, 32'h0, 1'b0);
    send_long("crc_bad0", 2'd0, 6'h2A, 16'd0, 0, -1, 1'b1, 32'h0, 1'b0);
    send_long("no_frame", 2'd1, 6'h2A, 16'd32, 0, -1, 1'b0, 32'h0, 1'b1);

    drive(4'hF, hdr(2'd0, 6'h01, 16'h0000));
    check("fe frame_valid", 32'(frame_valid_o), 0);
    check("fe err_sync", 32'(err_sync_o), 0);
    drive(4'h0, 32'h0);

    // Reset in the middle of a payload: outputs clear at once, nothing completes afterwards.
    drive(4'hF, hdr(2'd0, 6'h00, 16'h0042));
    drive(4'h0, 32'h0);
    check("reopen frame_num", 32'(frame_num_o), 32'h42);
    drive(4'hF, hdr(2'd0, 6'h2A, 16'd64));
    drive(4'hF, 32'h0102_0304);
    drive(4'hF, 32'h0506_0708);
    check("mid pix_valid", 32'(pix_valid_o), 1);
    reset_i = 1'b1;
    #1;
    check("mid_rst pix_valid", 32'(pix_valid_o), 0);
    check("mid_rst line_valid", 32'(line_valid_o), 0);
    check("mid_rst frame_valid", 32'(frame_valid_o), 0);
    check("mid_rst frame_num", 32'(frame_num_o), 0);
    drive(4'hF, 32'h090A_0B0C);
    reset_i = 1'b0;
    drive(4'h0, 32'h0);
    drive(4'hF, hdr(2'd0, 6'h00, 16'h0001));
    drive(4'h0, 32'h0);
    send_long("post_rst", 2'd0, 6'h2A, 16'd12, 0, -1, 1'b0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
